// File: rtl/rp_uart_pkg.sv
// rp_uart_pkg: shared definitions for the rp32 UART blocks.
//   - Register indices decoded from bus address bits [3:2].
//   - STATUS register bit positions.
//   - Transmitter FSM state encoding (uart_tx_st_t).
// Configuration macro: RP_UART_TX_PARITY_EN adds the PARITY state.
package rp_uart_pkg;

    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_STAT = 2'd1;
    localparam logic [1:0] UART_BAUD = 2'd2;
    localparam logic [1:0] UART_RSVD = 2'd3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_LVL   = 8;   // LSB of the 8-bit FIFO level field

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RP_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_st_t;

endpackage

// File: rtl/rp_fifo.sv
// rp_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (flushes pointers/level)
//   push,wdata write request and data; ignored when full
//   pop        read request; ignored when empty
//   rdata      head entry (valid while !empty)
//   full,empty occupancy flags
//   level      number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module rp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            // Simultaneous push and pop leaves the level unchanged.
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rp_uart_tx.sv
// rp_uart_tx: memory-mapped UART transmitter on the rp32 data bus.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus_req/wen/sel/adr/wdt  bus request (adr[3:2] selects the register)
//   bus_rdt               registered read data, held until the next read
//   bus_ack               combinational acknowledge, low only for a DATA
//                         push into a full FIFO
//   txd                   serial output, idle high
// Registers: 0 DATA (W push byte), 1 STATUS (R), 2 BAUD (R/W), 3 reserved.
// Configuration macro: RP_UART_TX_PARITY_EN -> 8E1 frames (11 bits),
// otherwise 8N1 (10 bits).
module rp_uart_tx
    import rp_uart_pkg::*;
#(
    parameter int          DAW = 16,
    parameter int          DDW = 32,
    parameter int          DSW = DDW/8,
    parameter int          FD  = 4,
    parameter logic [15:0] BDR = 16'd867
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bus_req,
    input  logic           bus_wen,
    input  logic [DSW-1:0] bus_sel,
    input  logic [DAW-1:0] bus_adr,
    input  logic [DDW-1:0] bus_wdt,
    output logic [DDW-1:0] bus_rdt,
    output logic           bus_ack,
    output logic           txd
);

    localparam int LW = $clog2(FD) + 1;

    logic [1:0]    reg_idx;
    logic          data_wr;
    logic          baud_wr;
    logic          bus_rd;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;

    logic [15:0]   baud;
    logic [15:0]   cnt;
    logic          bit_end;
    uart_tx_st_t   state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par;
    logic          busy;
    logic [DDW-1:0] status;
    logic [DDW-1:0] rd_val;

    // Only adr[3:2], wdt[15:0] and sel[1:0] are decoded; the register
    // block aliases across the rest of the address space.
    logic          unused_bits;
    assign unused_bits = ^{bus_adr[DAW-1:4], bus_adr[1:0],
                           bus_wdt[DDW-1:16], bus_sel[DSW-1:2]};

    assign reg_idx = bus_adr[3:2];
    assign data_wr = bus_req & bus_wen & (reg_idx == UART_DATA) & bus_sel[0];
    assign baud_wr = bus_req & bus_wen & (reg_idx == UART_BAUD);
    assign bus_rd  = bus_req & ~bus_wen;

    // A push into a full FIFO is stalled even if the FSM pops on this edge;
    // the requester holds the request and it lands on the next cycle.
    assign bus_ack   = ~(data_wr & fifo_full);
    assign fifo_push = data_wr & ~fifo_full;

    assign bit_end  = (cnt == 16'd0);
    assign busy     = (state != ST_IDLE);
    assign fifo_pop = ~fifo_empty &
                      ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

    rp_fifo #(
        .DEPTH (FD),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (bus_wdt[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Baud divisor, byte-writable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud <= BDR;
        end else if (baud_wr) begin
            if (bus_sel[0]) baud[7:0]  <= bus_wdt[7:0];
            if (bus_sel[1]) baud[15:8] <= bus_wdt[15:8];
        end
    end

    always_comb begin
        status                      = '0;
        status[STAT_EMPTY]          = fifo_empty;
        status[STAT_FULL]           = fifo_full;
        status[STAT_BUSY]           = busy;
        status[STAT_LVL +: 8]       = 8'(fifo_level);
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            UART_STAT: rd_val = status;
            UART_BAUD: rd_val = {{(DDW-16){1'b0}}, baud};
            UART_DATA: rd_val = '0;
            UART_RSVD: rd_val = '0;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdt <= '0;
        end else if (bus_rd) begin
            bus_rdt <= rd_val;
        end
    end

    // Transmit FSM. txd is registered from the current state, so the line
    // trails the state by one clock; every bit still lasts baud+1 clocks.
    // The baud counter reloads only at a bit boundary, so a BAUD write
    // mid-bit never shortens the bit in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            txd     <= 1'b1;
        end else begin
            if (state == ST_IDLE) begin
                if (!fifo_empty) cnt <= baud;
            end else begin
                cnt <= bit_end ? baud : cnt - 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift <= fifo_rdata;
                        par   <= ^fifo_rdata;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    txd <= shift[0];
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef RP_UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef RP_UART_TX_PARITY_EN
                ST_PARITY: begin
                    txd <= par;
                    if (bit_end) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        // Back-to-back frames: next START follows the stop
                        // bit with no idle gap.
                        if (!fifo_empty) begin
                            shift <= fifo_rdata;
                            par   <= ^fifo_rdata;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rp_uart_tx.sv
// tb_rp_uart_tx: self-checking bench for rp_uart_tx.
// Register-access vectors are table driven; frame, overflow, baud-change
// and reset sequences are hand written. Honours RP_UART_TX_PARITY_EN.
module tb_rp_uart_tx;

    localparam int FD = 4;
`ifdef RP_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LIMIT = 400;

    localparam logic [15:0] A_DATA = 16'h0000;
    localparam logic [15:0] A_STAT = 16'h0004;
    localparam logic [15:0] A_BAUD = 16'h0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_wen;
    logic [3:0]  bus_sel;
    logic [15:0] bus_adr;
    logic [31:0] bus_wdt;
    logic [31:0] bus_rdt;
    logic        bus_ack;
    logic        txd;

    int total;
    int bad;

    rp_uart_tx #(
        .FD (FD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_req (bus_req),
        .bus_wen (bus_wen),
        .bus_sel (bus_sel),
        .bus_adr (bus_adr),
        .bus_wdt (bus_wdt),
        .bus_rdt (bus_rdt),
        .bus_ack (bus_ack),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [15:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdt;
        logic        exp_ack;
        logic [31:0] exp_rdt;   // read result, or held value after a write
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic bus_wr(input logic [15:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int stall);
        bus_req = 1'b1; bus_wen = 1'b1; bus_adr = a; bus_sel = s; bus_wdt = d;
        stall = 0;
        #1;
        while (!bus_ack && stall < LIMIT) begin
            @(posedge clk); #1;
            stall++;
        end
        @(posedge clk); #1;
        bus_req = 1'b0; bus_wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        bus_req = 1'b1; bus_wen = 1'b0; bus_adr = a; bus_sel = 4'hF;
        @(posedge clk); #1;
        bus_req = 1'b0;
        d = bus_rdt;
    endtask

    // Checks one frame starting on the current cycle (first START cycle).
    // Frame bits 0..n1-1 last p1 clocks, the remaining bits p2 clocks.
    task automatic check_frame(input logic [7:0] d, input int p1, input int n1,
                               input int p2, input string tag);
        logic [10:0] fr;
        logic        ok;
        int          per;
        fr       = 11'h7FF;
        fr[0]    = 1'b0;
        fr[8:1]  = d;
`ifdef RP_UART_TX_PARITY_EN
        fr[9]    = ^d;
`endif
        for (int b = 0; b < NB; b++) begin
            per = (b < n1) ? p1 : p2;
            ok  = 1'b1;
            for (int k = 0; k < per; k++) begin
                if (txd !== fr[b]) ok = 1'b0;
                @(posedge clk); #1;
            end
            chk($sformatf("%s bit%0d", tag, b), {31'b0, ok}, 32'd1);
        end
    endtask

    task automatic send_check(input logic [7:0] d, input int per,
                              input string tag);
        int st;
        bus_wr(A_DATA, 4'h1, {24'b0, d}, st);
        chk({tag, " txd push edge"}, {31'b0, txd}, 32'd1);
        @(posedge clk); #1;
        chk({tag, " txd +1 edge"}, {31'b0, txd}, 32'd1);
        @(posedge clk); #1;
        check_frame(d, per, NB, per, tag);
    endtask

    task automatic wait_fall(input int lim);
        int n = 0;
        while (txd !== 1'b0 && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start bit seen", {31'b0, txd}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  bytes [6];
        int          stalls [6];
        int          st;
        logic        ok;

        total = 0; bad = 0;
        rst = 1'b1; bus_req = 1'b0; bus_wen = 1'b0;
        bus_sel = 4'h0; bus_adr = '0; bus_wdt = '0;

        vt[0]  = '{1'b0, 16'h0008, 4'hF, 32'h0,         1'b1, 32'h0000_0363};
        vt[1]  = '{1'b1, 16'h0008, 4'h3, 32'h0000_1234, 1'b1, 32'h0000_0363};
        vt[2]  = '{1'b0, 16'h0008, 4'hF, 32'h0,         1'b1, 32'h0000_1234};
        vt[3]  = '{1'b1, 16'h0008, 4'h1, 32'hFFFF_FF56, 1'b1, 32'h0000_1234};
        vt[4]  = '{1'b0, 16'h0008, 4'hF, 32'h0,         1'b1, 32'h0000_1256};
        vt[5]  = '{1'b1, 16'h0008, 4'h2, 32'h0000_AB00, 1'b1, 32'h0000_1256};
        vt[6]  = '{1'b0, 16'h0018, 4'hF, 32'h0,         1'b1, 32'h0000_AB56};
        vt[7]  = '{1'b1, 16'h0004, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0000_AB56};
        vt[8]  = '{1'b0, 16'h0034, 4'hF, 32'h0,         1'b1, 32'h0000_0001};
        vt[9]  = '{1'b1, 16'h000C, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001};
        vt[10] = '{1'b0, 16'h000C, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
        vt[11] = '{1'b1, 16'h0000, 4'hE, 32'h0000_0055, 1'b1, 32'h0000_0000};
        vt[12] = '{1'b0, 16'h0004, 4'hF, 32'h0,         1'b1, 32'h0000_0001};
        vt[13] = '{1'b0, 16'h0000, 4'hF, 32'h0,         1'b1, 32'h0000_0000};
        vt[14] = '{1'b1, 16'h0008, 4'h3, 32'h0000_0003, 1'b1, 32'h0000_0000};
        vt[15] = '{1'b0, 16'h0008, 4'hF, 32'h0,         1'b1, 32'h0000_0003};

        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hF0;
        bytes[3] = 8'h0F; bytes[4] = 8'hAA; bytes[5] = 8'h3C;

        // Reset released mid-cycle.
        #22 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset txd", {31'b0, txd}, 32'd1);
        chk("reset ack", {31'b0, bus_ack}, 32'd1);
        chk("reset rdt", bus_rdt, 32'd0);
        bus_rd(A_STAT, rd);
        chk("reset status", rd, 32'h0000_0001);

        // Register access table; leaves BAUD = 3.
        for (int i = 0; i < 16; i++) begin
            bus_req = 1'b1; bus_wen = vt[i].wen; bus_adr = vt[i].adr;
            bus_sel = vt[i].sel; bus_wdt = vt[i].wdt;
            #1;
            chk($sformatf("vec%0d ack", i), {31'b0, bus_ack}, {31'b0, vt[i].exp_ack});
            @(posedge clk); #1;
            bus_req = 1'b0; bus_wen = 1'b0;
            chk($sformatf("vec%0d rdt", i), bus_rdt, vt[i].exp_rdt);
        end

        // 0x55 at BAUD=3 with a STATUS poll mid-frame.
        bus_wr(A_DATA, 4'h1, 32'h55, st);
        chk("f55 txd push edge", {31'b0, txd}, 32'd1);
        @(posedge clk); #1;
        chk("f55 txd +1 edge", {31'b0, txd}, 32'd1);
        @(posedge clk); #1;
        fork
            check_frame(8'h55, 4, NB, 4, "f55");
            begin
                repeat (8) @(posedge clk);
                #1;
                bus_rd(A_STAT, rd);
                chk("status busy mid-frame", rd, 32'h0000_0005);
            end
        join
        bus_rd(A_STAT, rd);
        chk("status idle after frame", rd, 32'h0000_0001);

        // Parity-relevant bytes (plain 8N1 in the default build).
        send_check(8'h07, 4, "f07");
        send_check(8'h03, 4, "f03");

        // BAUD=0: one clock per bit.
        bus_wr(A_BAUD, 4'h3, 32'h0, st);
        send_check(8'hC5, 1, "fC5");

        // Baud change during data bit 2.
        bus_wr(A_BAUD, 4'h3, 32'h7, st);
        bus_wr(A_DATA, 4'h1, 32'hA3, st);
        @(posedge clk); #1;
        @(posedge clk); #1;
        fork
            check_frame(8'hA3, 8, 4, 2, "fA3");
            begin
                repeat (26) @(posedge clk);
                #1;
                bus_wr(A_BAUD, 4'h3, 32'h1, st);
            end
        join

        // FIFO overflow with back-to-back frames.
        bus_wr(A_BAUD, 4'h3, 32'h9, st);
        fork
            begin
                wait_fall(10);
                for (int i = 0; i < 6; i++)
                    check_frame(bytes[i], 10, NB, 10, $sformatf("ovf%0d", i));
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    bus_wr(A_DATA, 4'h1, {24'b0, bytes[i]}, st);
                    stalls[i] = st;
                end
            end
        join
        for (int i = 0; i < 5; i++)
            chk($sformatf("ovf stall%0d", i), stalls[i], 32'd0);
        chk("ovf stall5", stalls[5], 1 + NB*10 - 4);
        bus_rd(A_STAT, rd);
        chk("status after overflow", rd, 32'h0000_0001);

        // Reset in the middle of a frame.
        bus_wr(A_DATA, 4'h1, 32'h00, st);
        repeat (15) @(posedge clk);
        #1;
        chk("txd low mid-frame", {31'b0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("txd async reset", {31'b0, txd}, 32'd1);
        chk("ack in reset", {31'b0, bus_ack}, 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus_rd(A_STAT, rd);
        chk("status after reset", rd, 32'h0000_0001);
        bus_rd(A_BAUD, rd);
        chk("baud after reset", rd, 32'h0000_0363);
        ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (txd !== 1'b1) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("txd idle after abort", {31'b0, ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rp_uart_tx.md
# rp_uart_tx

Memory-mapped UART transmitter that acts as a responder on the rp32 data bus (`bud_*` request/acknowledge protocol), in the same bus position as the data memory. The core writes bytes into a small transmit FIFO; a baud-rate generator and serializer shift them out as 8N1 frames on `txd`. A status register lets software poll FIFO occupancy and line activity.

## Interface
- `DAW`, 16, data bus address width (only `adr[3:2]` decoded)
- `DDW`, 32, data bus data width
- `DSW`, `DDW/8`, byte select width
- `FD`, 4, TX FIFO depth in bytes (power of 2, ≥2)
- `BDR`, 16'd867, reset value of baud divisor (bit period = BDR+1 clocks)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `bus_req`  in  1  transfer request
- `bus_wen`  in  1  1 = write, 0 = read
- `bus_sel`  in  DSW  byte enables
- `bus_adr`  in  DAW  byte address
- `bus_wdt`  in  DDW  write data
- `bus_rdt`  out  DDW  read data
- `bus_ack`  out  1  transfer acknowledge
- `txd`  out  1  serial output, idle high

## Operation
- Transfer completes on a rising edge where `bus_req & bus_ack`.
- Register map (`adr[3:2]`): 0 DATA (W: push `wdt[7:0]` if `sel[0]`; R: 0); 1 STATUS (R: `[0]` FIFO empty, `[1]` FIFO full, `[2]` busy, `[15:8]` FIFO level; W ignored); 2 BAUD (R/W `[15:0]`, byte-enable per `sel[1:0]`); 3 reserved (R: 0, W ignored).
- Unused address bits ignored (register block aliases across address space).
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE→START when FIFO not empty; pop byte into shift register same edge.
  - START: `txd`=0 for one bit period → DATA.
  - DATA: 8 bits LSB first, bit counter 0..7 → STOP (or PARITY).
  - STOP: `txd`=1 one bit period → START if FIFO not empty (back-to-back, no idle gap), else IDLE.
- Baud counter counts down from BAUD to 0; bit boundary at 0, reloads BAUD. BAUD writes take effect at next reload; mid-bit change never truncates current bit.
- BAUD=0 legal: one clock per bit.
- busy = FSM not IDLE.

## Timing
- Reset values: `bus_ack`=1, `bus_rdt`=0, `txd`=1, FSM IDLE, FIFO empty, BAUD=BDR.
- `bus_ack` combinational: 0 only when `req & wen`, DATA address, `sel[0]`, FIFO full; otherwise 1. Requester holds signals until acked.
- Read data registered: `bus_rdt` valid on the cycle after the acknowledged read; holds value until next read completes.
- Write to DATA when FIFO full and pop on same edge: push stalled (ack=0 this cycle), accepted next cycle.
- Push into empty FIFO while IDLE: START begins 1 cycle after push edge (`txd` falls 2 edges after push).
- Simultaneous push and pop: level unchanged.
- Reset mid-frame: `txd` returns high immediately (async), FIFO flushed, frame aborted.

## Configuration
- `RP_UART_TX_PARITY_EN`: defined → PARITY state inserted between DATA and STOP, emits even parity (XOR of 8 data bits), frame 11 bits. Undefined → 8N1, 10-bit frame, PARITY state absent from enum.

## Structure
- Package `rp_uart_pkg`: register index constants (`UART_DATA`, `UART_STAT`, `UART_BAUD`), FSM state enum `uart_tx_st_t`, status bit positions.
- Sub-module `rp_fifo` (parameter depth/width, push/pop/full/empty/level); reusable for later RX block.
- Top holds bus decode, baud counter, FSM, shift register.

## Test plan
- Reset: assert `rst` async mid-cycle → `txd`=1, `bus_ack`=1, STATUS read returns 0x0000_0001.
- BAUD=3, write 0x55 → `txd` low 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, then high 4 clocks; busy=1 during frame.
- FIFO overflow: BAUD=9, write 6 bytes back-to-back with FD=4 → 5 accepted immediately (1 popped + 4 queued), 6th has `bus_ack`=0 until STOP of first frame pops; all 6 frames transmitted without gap.
- Sel mask: write DATA with `sel`=4'b1110 → no push, ack=1, STATUS empty stays 1.
- BAUD change mid-frame: BAUD=7, write 0xA3, set BAUD=1 during bit 2 → bit 2 lasts 8 clocks, bit 3 onward 2 clocks.
- With `RP_UART_TX_PARITY_EN`: send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame 11 bit periods.
